// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared widths, waveform encodings and square levels for the bank oscillator
package osc_pkg;

    localparam int DEF_PHASE_W = 24;
    localparam int DEF_IDX_W   = 11;
    localparam int DEF_SMP_W   = 16;
    localparam int DEF_OUT_W   = 24;
    localparam int DEF_NBANKS  = 10;
    localparam int DEF_MIDI_W  = 7;

    typedef enum logic [1:0] {
        MODE_SAW  = 2'd0,
        MODE_SQR  = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_MUTE = 2'd3
    } osc_mode_e;

    function automatic int sqr_high(int smp_w);
        return (2 ** (smp_w - 1)) - 1;
    endfunction

    function automatic int sqr_low(int smp_w);
        return -(2 ** (smp_w - 1));
    endfunction

endpackage

// File: rtl/wave_shape_lut.sv
// rtl/wave_shape_lut.sv - combinational waveform lookup for one table index
module wave_shape_lut
    import osc_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int SMP_W = DEF_SMP_W
) (
    input  osc_mode_e                mode,
    input  logic [IDX_W-1:0]         idx,
    input  logic [IDX_W-1:0]         pw,
    output logic signed [SMP_W-1:0]  sample
);

    localparam logic signed [SMP_W-1:0] SQR_HI = SMP_W'(sqr_high(SMP_W));
    localparam logic signed [SMP_W-1:0] SQR_LO = SMP_W'(sqr_low(SMP_W));

    logic [IDX_W-2:0]        fold;
    logic signed [SMP_W-1:0] saw_val;
    logic signed [SMP_W-1:0] tri_val;

    // Saw and triangle tables are generated from the index bits: inverting the
    // MSB turns an unsigned ramp into a two's complement ramp centred on zero.
    always_comb begin
        fold    = idx[IDX_W-1] ? ~idx[IDX_W-2:0] : idx[IDX_W-2:0];
        saw_val = {~idx[IDX_W-1], idx[IDX_W-2:0], {(SMP_W-IDX_W){1'b0}}};
        tri_val = {~fold[IDX_W-2], fold[IDX_W-3:0], {(SMP_W-IDX_W+1){1'b0}}};
        sample  = '0;
        unique case (mode)
            MODE_SAW:  sample = saw_val;
            MODE_SQR:  sample = (idx < pw) ? SQR_HI : SQR_LO;
            MODE_TRI:  sample = tri_val;
            MODE_MUTE: sample = '0;
        endcase
    end

endmodule

// File: rtl/multi_wave_osc.sv
// rtl/multi_wave_osc.sv - four-stage interpolating multi-waveform bank oscillator
module multi_wave_osc
    import osc_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int FRAC_W  = PHASE_W - IDX_W,
    parameter int SMP_W   = DEF_SMP_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NBANKS  = DEF_NBANKS,
    parameter int TAG_W   = $clog2(NBANKS),
    parameter int MIDI_W  = DEF_MIDI_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     wav_en,
    input  logic                     i_valid,
    input  logic [PHASE_W-1:0]       i_phase,
    input  logic [1:0]               i_mode,
    input  logic [IDX_W-1:0]         i_pw,
    input  logic [TAG_W-1:0]         i_tag,
    input  logic [MIDI_W-1:0]        i_midi,
    output logic                     o_valid,
    output logic [TAG_W-1:0]         o_tag,
    output logic [MIDI_W-1:0]        o_midi,
    output logic signed [OUT_W-1:0]  o_sample,
    output logic                     o_tag_err
);

    localparam int SHIFT  = SMP_W + FRAC_W - OUT_W;
    localparam int PROD_W = SMP_W + FRAC_W + 2;

    logic                    s1_valid, s2_valid, s3_valid;
    logic [TAG_W-1:0]        s1_tag, s2_tag, s3_tag;
    logic [MIDI_W-1:0]       s1_midi, s2_midi, s3_midi;
    osc_mode_e               s1_mode;
    logic [IDX_W-1:0]        s1_idx0, s1_idx1, s1_pw;
    logic [FRAC_W-1:0]       s1_frac, s2_frac;
    logic signed [SMP_W-1:0] s2_s0, s2_s1, s3_a0, s3_a1;
    logic [FRAC_W:0]         s3_b0, s3_b1;
    logic signed [SMP_W-1:0] lut_s0, lut_s1;
    logic signed [PROD_W-1:0] prod0, prod1, sum;

    wave_shape_lut #(.IDX_W(IDX_W), .SMP_W(SMP_W)) u_lut0 (
        .mode(s1_mode), .idx(s1_idx0), .pw(s1_pw), .sample(lut_s0)
    );
    wave_shape_lut #(.IDX_W(IDX_W), .SMP_W(SMP_W)) u_lut1 (
        .mode(s1_mode), .idx(s1_idx1), .pw(s1_pw), .sample(lut_s1)
    );

    // Weights are zero-extended before the signed multiply so they stay positive.
    always_comb begin
        prod0 = PROD_W'(s3_a0) * PROD_W'($signed({1'b0, s3_b0}));
        prod1 = PROD_W'(s3_a1) * PROD_W'($signed({1'b0, s3_b1}));
        sum   = prod0 + prod1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0;
            s1_tag    <= '0;   s2_tag   <= '0;   s3_tag   <= '0;
            s1_midi   <= '0;   s2_midi  <= '0;   s3_midi  <= '0;
            s1_mode   <= MODE_SAW;
            s1_idx0   <= '0;   s1_idx1  <= '0;   s1_pw    <= '0;
            s1_frac   <= '0;   s2_frac  <= '0;
            s2_s0     <= '0;   s2_s1    <= '0;
            s3_a0     <= '0;   s3_a1    <= '0;
            s3_b0     <= '0;   s3_b1    <= '0;
            o_valid   <= 1'b0;
            o_tag     <= '0;
            o_midi    <= '0;
            o_sample  <= '0;
            o_tag_err <= 1'b0;
        end else if (!wav_en) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_tag    <= '0;
            o_midi   <= '0;
            o_sample <= '0;
        end else if (clk_en) begin
            s1_valid <= i_valid;
            s1_tag   <= i_tag;
            s1_midi  <= i_midi;
            s1_mode  <= osc_mode_e'(i_mode);
            s1_pw    <= i_pw;
            s1_idx0  <= i_phase[PHASE_W-1 -: IDX_W];
            s1_idx1  <= i_phase[PHASE_W-1 -: IDX_W] + IDX_W'(1);
            s1_frac  <= i_phase[FRAC_W-1:0];

            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_midi  <= s1_midi;
            s2_s0    <= lut_s0;
            s2_s1    <= lut_s1;
            s2_frac  <= s1_frac;

            s3_valid <= s2_valid;
            s3_tag   <= s2_tag;
            s3_midi  <= s2_midi;
            s3_a0    <= s2_s0;
            s3_a1    <= s2_s1;
            s3_b0    <= {1'b1, {FRAC_W{1'b0}}} - {1'b0, s2_frac};
            s3_b1    <= {1'b0, s2_frac};

            o_valid  <= s3_valid;
            o_tag    <= s3_tag;
            o_midi   <= s3_midi;
            o_sample <= s3_valid ? OUT_W'(sum >>> SHIFT) : '0;

            if (i_valid && ({1'b0, i_tag} >= (TAG_W+1)'(NBANKS)))
                o_tag_err <= 1'b1;
        end
    end

endmodule
